// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU share arbiter: RV32I funct3/funct7 codes,
// ALU opcode constants, requester IDs and the response slot state encoding.
package alu_share_arb_pkg;

   // funct3 operation select
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct7: base selects ADD/SRL, alt selects SUB/SRA
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // ALU-relevant major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   // requester IDs
   localparam int              ID_W    = 1;
   localparam logic [ID_W-1:0] ID_REQ0 = 1'b0;
   localparam logic [ID_W-1:0] ID_REQ1 = 1'b1;

   // response slot states
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // control fields handed to the ALU
   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
   } alu_ctl_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin picker. A lone valid requester always wins; on a tie
// the requester that did not win last time is chosen. No grant when disabled.
import alu_share_arb_pkg::*;

module rr_arb2 (
   input  logic [1:0]      valid_i,
   input  logic            enable_i,
   input  logic [ID_W-1:0] last_i,
   output logic [1:0]      grant_o,
   output logic [ID_W-1:0] sel_o
);

   // one-hot grant, tie broken against the previous winner
   always_comb begin
      grant_o = 2'b00;
      if (enable_i) begin
         if (valid_i == 2'b11) grant_o = (last_i == ID_REQ1) ? 2'b01 : 2'b10;
         else                  grant_o = valid_i;
      end
   end

   // no grant falls back to requester 0 so the ALU sees req0 fields
   assign sel_o = grant_o[1] ? ID_REQ1 : ID_REQ0;

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational RV32I ALU between two requesters with round-robin
// arbitration and a single registered, ID-tagged response slot.
// Optional feature: define ALU_ARB_PERF_EN to add grant/conflict counters.
import alu_share_arb_pkg::*;

module alu_share_arb #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [6:0]      req0_opcode,
   input  logic [2:0]      req0_funct3,
   input  logic [6:0]      req0_funct7,
   input  logic [XLEN-1:0] req0_in1,
   input  logic [XLEN-1:0] req0_in2,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [6:0]      req1_opcode,
   input  logic [2:0]      req1_funct3,
   input  logic [6:0]      req1_funct7,
   input  logic [XLEN-1:0] req1_in1,
   input  logic [XLEN-1:0] req1_in2,
   output logic [6:0]      alu_opcode,
   output logic [2:0]      alu_funct3,
   output logic [6:0]      alu_funct7,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   input  logic [XLEN-1:0] alu_out,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [ID_W-1:0] rsp_id,
   output logic [XLEN-1:0] rsp_data
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_cnt0,
   output logic [CNT_W-1:0] perf_cnt1,
   output logic [CNT_W-1:0] perf_conflict
`endif
);

   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [ID_W-1:0] last_q, last_d;
   logic            can_accept;
   logic [1:0]      grant;
   logic [ID_W-1:0] sel;
   alu_ctl_t        ctl0, ctl1, ctl_sel;

   // slot can take a new result when empty or being drained this cycle;
   // held off entirely while in reset so no ready escapes
   assign can_accept = rst_n & ((state_q == ST_EMPTY) | rsp_ready);

   rr_arb2 u_arb (
      .valid_i  ({req1_valid, req0_valid}),
      .enable_i (can_accept),
      .last_i   (last_q),
      .grant_o  (grant),
      .sel_o    (sel)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   assign ctl0 = '{opcode: req0_opcode, funct3: req0_funct3, funct7: req0_funct7};
   assign ctl1 = '{opcode: req1_opcode, funct3: req1_funct3, funct7: req1_funct7};

   // operand mux toward the external ALU, follows the grant combinationally
   always_comb begin
      ctl_sel = ctl0;
      alu_in1 = req0_in1;
      alu_in2 = req0_in2;
      if (sel == ID_REQ1) begin
         ctl_sel = ctl1;
         alu_in1 = req1_in1;
         alu_in2 = req1_in2;
      end
   end

   assign alu_opcode = ctl_sel.opcode;
   assign alu_funct3 = ctl_sel.funct3;
   assign alu_funct7 = ctl_sel.funct7;

   // slot next state: a grant refills (even while draining), otherwise a drain empties
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      last_d  = last_q;
      if (|grant) begin
         state_d = ST_FULL;
         data_d  = alu_out;
         id_d    = sel;
         last_d  = sel;
      end else if (rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // slot registers; reset leaves last=1 so req0 takes the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= ID_REQ0;
         last_q  <= ID_REQ1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;

`ifdef ALU_ARB_PERF_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q, conf_q;

   // free-running wrap-around counters: grants per requester and contended cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
         conf_q <= '0;
      end else begin
         cnt0_q <= cnt0_q + CNT_W'(grant[0]);
         cnt1_q <= cnt1_q + CNT_W'(grant[1]);
         conf_q <= conf_q + CNT_W'(req0_valid & req1_valid & can_accept);
      end
   end

   assign perf_cnt0     = cnt0_q;
   assign perf_cnt1     = cnt1_q;
   assign perf_conflict = conf_q;
`else
   // counter width only matters when the counters are built
   logic unused_cnt_w;
   assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized
// traffic against a behavioural slot/arbiter model and an RV32I ALU model.
module tb_alu_share_arb;
   import alu_share_arb_pkg::*;

   localparam int XLEN = 32;
   localparam int CW   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
   logic req0_ready, req1_ready;
   logic [6:0] req0_opcode = 0, req1_opcode = 0, req0_funct7 = 0, req1_funct7 = 0;
   logic [2:0] req0_funct3 = 0, req1_funct3 = 0;
   logic [31:0] req0_in1 = 0, req0_in2 = 0, req1_in1 = 0, req1_in2 = 0;
   logic [6:0] alu_opcode, alu_funct7;
   logic [2:0] alu_funct3;
   logic [31:0] alu_in1, alu_in2, alu_out;
   logic rsp_valid;
   logic [0:0] rsp_id;
   logic [31:0] rsp_data;
`ifdef ALU_ARB_PERF_EN
   logic [CW-1:0] perf_cnt0, perf_cnt1, perf_conflict;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // reference RV32I ALU
   function automatic logic [31:0] alu_f(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (f3)
         F3_ADD_SUB: return (opc == OPC_OP && f7 == F7_ALT) ? a - b : a + b;
         F3_SLL:     return a << sh;
         F3_SLT:     return {31'b0, $signed(a) < $signed(b)};
         F3_SLTU:    return {31'b0, a < b};
         F3_XOR:     return a ^ b;
         F3_SRL_SRA: return (f7 == F7_ALT) ? 32'($signed(a) >>> sh) : a >> sh;
         F3_OR:      return a | b;
         default:    return a & b;
      endcase
   endfunction

   assign alu_out = alu_f(alu_opcode, alu_funct3, alu_funct7, alu_in1, alu_in2);

   alu_share_arb #(.XLEN(XLEN), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_in1(req0_in1), .req0_in2(req0_in2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_in1(req1_in1), .req1_in2(req1_in2),
      .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ALU_ARB_PERF_EN
      , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1), .perf_conflict(perf_conflict)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_known = 0;
   logic        m_valid = 0, m_id = 0, m_last = 1;
   logic [31:0] m_data = 0;
   int          m_c0 = 0, m_c1 = 0, m_cf = 0;

   // outputs are checked mid-cycle; then the model steps to the next edge
   always @(negedge clk) begin
      logic ca, g0, g1;
      ca = !m_valid || rsp_ready;
      g0 = 0;
      g1 = 0;
      if (rst_n && ca) begin
         if (req0_valid && req1_valid) begin
            if (m_last) g0 = 1; else g1 = 1;
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
      if (m_known) begin
         chk("req0_ready", req0_ready, g0);
         chk("req1_ready", req1_ready, g1);
         chk("alu_opcode", alu_opcode, g1 ? req1_opcode : req0_opcode);
         chk("alu_funct3", alu_funct3, g1 ? req1_funct3 : req0_funct3);
         chk("alu_funct7", alu_funct7, g1 ? req1_funct7 : req0_funct7);
         chk("alu_in1", alu_in1, g1 ? req1_in1 : req0_in1);
         chk("alu_in2", alu_in2, g1 ? req1_in2 : req0_in2);
         chk("rsp_valid", rsp_valid, m_valid);
         chk("rsp_id", rsp_id, m_id);
         chk("rsp_data", rsp_data, m_data);
`ifdef ALU_ARB_PERF_EN
         chk("perf_cnt0", perf_cnt0, m_c0);
         chk("perf_cnt1", perf_cnt1, m_c1);
         chk("perf_conflict", perf_conflict, m_cf);
`endif
      end
      if (!rst_n) begin
         m_known = 1;
         m_valid = 0; m_id = 0; m_data = 0; m_last = 1;
         m_c0 = 0; m_c1 = 0; m_cf = 0;
      end else begin
         if (req0_valid && req1_valid && ca) m_cf = (m_cf + 1) % (1 << CW);
         if (g0) m_c0 = (m_c0 + 1) % (1 << CW);
         if (g1) m_c1 = (m_c1 + 1) % (1 << CW);
         if (g0 || g1) begin
            m_valid = 1;
            m_id    = g1;
            m_last  = g1;
            m_data  = g1 ? alu_f(req1_opcode, req1_funct3, req1_funct7, req1_in1, req1_in2)
                         : alu_f(req0_opcode, req0_funct3, req0_funct7, req0_in1, req0_in2);
         end else if (rsp_ready) begin
            m_valid = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_opcode = opc; req0_funct3 = f3; req0_funct7 = f7;
      req0_in1 = a; req0_in2 = b;
   endtask

   task automatic set1(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_opcode = opc; req1_funct3 = f3; req1_funct7 = f7;
      req1_in1 = a; req1_in2 = b;
   endtask

   initial begin
      repeat (3) tick();
      @(negedge clk);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);

      // 1: req0 alone, ADD 5+7
      tick();
      rst_n = 1; rsp_ready = 1;
      set0(1, OPC_OP, F3_ADD_SUB, F7_BASE, 32'd5, 32'd7);
      @(negedge clk); chk("t1_ready0", req0_ready, 1);
      tick(); req0_valid = 0;
      @(negedge clk);
      chk("t1_valid", rsp_valid, 1); chk("t1_id", rsp_id, 0); chk("t1_data", rsp_data, 12);
      tick();

      // 4: req1 alone, SRA 0x80000000 >>> 4
      set1(1, OPC_OP, F3_SRL_SRA, F7_ALT, 32'h8000_0000, 32'd4);
      @(negedge clk); chk("t4_ready1", req1_ready, 1);
      tick(); req1_valid = 0;
      @(negedge clk); chk("t4_id", rsp_id, 1); chk("t4_data", rsp_data, 32'hF800_0000);
      tick();

      // 2: both valid every cycle, alternating grants starting with req0
      set0(1, OPC_OP, F3_ADD_SUB, F7_ALT, 32'd10, 32'd3);
      set1(1, OPC_OP, F3_XOR, F7_BASE, 32'hF0, 32'h0F);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t2_ready0", req0_ready, (k % 2) == 0);
         chk("t2_ready1", req1_ready, (k % 2) == 1);
         if (k > 0) chk("t2_data", rsp_data, ((k - 1) % 2 == 0) ? 32'd7 : 32'hFF);
         tick();
      end

      // 3: stall with slot full, then drain and refill in one cycle
      rsp_ready = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t3_stall_r0", req0_ready, 0); chk("t3_stall_r1", req1_ready, 0);
         chk("t3_hold_id", rsp_id, 1); chk("t3_hold_data", rsp_data, 32'hFF);
         tick();
      end
      rsp_ready = 1;
      @(negedge clk); chk("t3_regrant0", req0_ready, 1);
      tick();
      @(negedge clk); chk("t3_valid", rsp_valid, 1); chk("t3_data", rsp_data, 7);

      // 5: reset while full with both valid
      tick(); rsp_ready = 0;
      tick(); rst_n = 0;
      @(negedge clk); chk("t5_r0", req0_ready, 0); chk("t5_r1", req1_ready, 0);
      tick();
      @(negedge clk); chk("t5_valid", rsp_valid, 0);
      tick(); rst_n = 1; rsp_ready = 1;
      @(negedge clk); chk("t5_tie0", req0_ready, 1); chk("t5_tie1", req1_ready, 0);
      tick();

`ifdef ALU_ARB_PERF_EN
      // 6: counters, then conflict counter wrap (CW=4)
      rst_n = 0; tick(); rst_n = 1; rsp_ready = 1;
      req0_valid = 1; req1_valid = 1;
      repeat (3) tick();
      req0_valid = 0;
      repeat (2) tick();
      req1_valid = 0;
      @(negedge clk);
      chk("t6_cnt0", perf_cnt0, 2); chk("t6_cnt1", perf_cnt1, 3); chk("t6_conf", perf_conflict, 3);
      req0_valid = 1; req1_valid = 1;
      repeat (13) tick();
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk("t6_wrap", perf_conflict, 0); chk("t6_cnt0b", perf_cnt0, 9); chk("t6_cnt1b", perf_cnt1, 9);
      tick();
`endif

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         rst_n     = ($urandom_range(0, 99) >= 2);
         rsp_ready = ($urandom_range(0, 9) < 7);
         set0($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? OPC_OP : OPC_OP_IMM,
              3'($urandom), $urandom_range(0, 1) ? F7_ALT : F7_BASE, $urandom, $urandom);
         set1($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? OPC_OP : OPC_OP_IMM,
              3'($urandom), $urandom_range(0, 1) ? F7_ALT : F7_BASE, $urandom, $urandom);
         tick();
      end
      req0_valid = 0; req1_valid = 0; rst_n = 1;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
